ov7670_dvp_gen: RTL and testbench

OV7670_DVP_GEN -- requirements
Module: ov7670_dvp_gen

---
 rtl/ov7670_dvp_gen_pkg.sv | 34 +++
 rtl/ov7670_pattern_rom.sv | 34 +++
 rtl/ov7670_dvp_gen.sv | 181 ++++++++++++++++++
 tb/tb_ov7670_dvp_gen.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_dvp_gen_pkg.sv
// Shared types and widths for the OV7670 DVP test-pattern generator.
// The optional checksum output is controlled by OV7670_DVP_GEN_CHKSUM_EN.
package ov7670_dvp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_INDEX = 2'd3
    } pattern_e;

    localparam int c_pix_w  = 12;
    localparam int c_chan_w = 4;
    localparam int c_byte_w = 8;
    localparam int c_pos_w  = 12;
    localparam int c_cnt_w  = 24;

    // RGB444 on an 8-bit bus: first byte {0000,R}, second byte {G,B}.
    function automatic logic [c_byte_w-1:0] pack_byte(input logic [c_pix_w-1:0] pix,
                                                      input logic               second);
        return second ? pix[2*c_chan_w-1:0]
                      : {{(c_byte_w-c_chan_w){1'b0}}, pix[c_pix_w-1:2*c_chan_w]};
    endfunction

endpackage

// File: rtl/ov7670_pattern_rom.sv
// Combinational pixel source: maps pattern, column, row and solid colour
// to a 12-bit RGB444 pixel.
module ov7670_pattern_rom
    import ov7670_dvp_gen_pkg::*;
#(
    parameter int c_img_cols = 80
) (
    input  pattern_e             pattern,
    input  logic [c_pos_w-1:0]   col,
    input  logic [c_pos_w-1:0]   row,
    input  logic [c_pix_w-1:0]   solid_rgb,
    output logic [c_pix_w-1:0]   pixel
);

    logic [c_pos_w+2:0] bar_num;
    logic [2:0]         bar;
    logic [c_pix_w-1:0] index;

    always_comb begin
        bar_num = {col, 3'b000};
        bar     = 3'(bar_num / (c_pos_w+3)'(c_img_cols));
        // Index wraps modulo 2^12, so 12-bit arithmetic gives the truncated value directly.
        index   = c_pix_w'(row * c_pix_w'(c_img_cols) + col);
        pixel   = '0;
        case (pattern)
            PAT_SOLID: pixel = solid_rgb;
            PAT_GRAD:  pixel = {col[3:0], row[3:0], 4'h0};
            PAT_BARS:  pixel = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            PAT_INDEX: pixel = index;
            default:   pixel = '0;
        endcase
    end

endmodule

// File: rtl/ov7670_dvp_gen.sv
// OV7670-style DVP frame generator (pclk = clk/2, vsync/href/d timing + test patterns).
// Define OV7670_DVP_GEN_CHKSUM_EN to add the frame_sum checksum output.
module ov7670_dvp_gen
    import ov7670_dvp_gen_pkg::*;
#(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_vsync_lines  = 3,
    parameter int c_vback_lines  = 17,
    parameter int c_vfront_lines = 10,
    parameter int c_hblank_pclk  = 144
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          pattern_sel,
    input  logic [c_pix_w-1:0]  solid_rgb,
    output logic                pclk,
    output logic                vsync,
    output logic                href,
    output logic [c_byte_w-1:0] d,
    output logic                frame_done,
`ifdef OV7670_DVP_GEN_CHKSUM_EN
    output logic [15:0]         frame_sum,
`endif
    output state_e              dbg_state
);

    localparam int c_line = 2*c_img_cols + c_hblank_pclk;
    localparam logic [c_cnt_w-1:0] c_vsync_last  = c_cnt_w'(c_vsync_lines*c_line - 1);
    localparam logic [c_cnt_w-1:0] c_vback_last  = c_cnt_w'(c_vback_lines*c_line - 1);
    localparam logic [c_cnt_w-1:0] c_vfront_last = c_cnt_w'(c_vfront_lines*c_line - 1);
    localparam logic [c_cnt_w-1:0] c_hblank_last = c_cnt_w'(c_hblank_pclk - 1);
    localparam logic [c_pos_w-1:0] c_col_last    = c_pos_w'(c_img_cols - 1);
    localparam logic [c_pos_w-1:0] c_row_last    = c_pos_w'(c_img_rows - 1);

    logic               pclk_q;
    state_e             state_q, state_n;
    logic [c_cnt_w-1:0] cnt_q, cnt_n;
    logic [c_pos_w-1:0] col_q, col_n, row_q, row_n;
    logic               byte_q, byte_n;
    logic               load_n, done_n;
    pattern_e           pat_q;
    logic [c_pix_w-1:0] solid_q, pixel;
    logic               frame_done_q;

    // pclk high means the next clk edge is the falling pclk edge: the only edge where state moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pclk_q <= 1'b0;
        else     pclk_q <= ~pclk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            byte_q       <= 1'b0;
            pat_q        <= PAT_SOLID;
            solid_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= pclk_q & done_n;
            if (pclk_q) begin
                state_q <= state_n;
                cnt_q   <= cnt_n;
                col_q   <= col_n;
                row_q   <= row_n;
                byte_q  <= byte_n;
                if (load_n) begin
                    pat_q   <= pattern_e'(pattern_sel);
                    solid_q <= solid_rgb;
                end
            end
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        col_n   = col_q;
        row_n   = row_q;
        byte_n  = byte_q;
        load_n  = 1'b0;
        done_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_VSYNC;
                    cnt_n   = '0;
                    load_n  = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (cnt_q == c_vsync_last) begin
                    state_n = ST_VBACK;
                    cnt_n   = '0;
                end else cnt_n = cnt_q + 1'b1;
            end
            ST_VBACK: begin
                if (cnt_q == c_vback_last) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                    col_n   = '0;
                    row_n   = '0;
                    byte_n  = 1'b0;
                end else cnt_n = cnt_q + 1'b1;
            end
            ST_ACTIVE: begin
                if (byte_q) begin
                    byte_n = 1'b0;
                    if (col_q == c_col_last) begin
                        col_n   = '0;
                        cnt_n   = '0;
                        state_n = ST_HBLANK;
                    end else col_n = col_q + 1'b1;
                end else byte_n = 1'b1;
            end
            ST_HBLANK: begin
                if (cnt_q == c_hblank_last) begin
                    cnt_n = '0;
                    if (row_q == c_row_last) begin
                        row_n   = '0;
                        state_n = ST_VFRONT;
                    end else begin
                        row_n   = row_q + 1'b1;
                        state_n = ST_ACTIVE;
                    end
                end else cnt_n = cnt_q + 1'b1;
            end
            ST_VFRONT: begin
                if (cnt_q == c_vfront_last) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else cnt_n = cnt_q + 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    ov7670_pattern_rom #(
        .c_img_cols(c_img_cols)
    ) u_rom (
        .pattern   (pat_q),
        .col       (col_q),
        .row       (row_q),
        .solid_rgb (solid_q),
        .pixel     (pixel)
    );

    assign pclk       = pclk_q;
    assign vsync      = (state_q == ST_VSYNC);
    assign href       = (state_q == ST_ACTIVE);
    assign d          = href ? pack_byte(pixel, byte_q) : '0;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

`ifdef OV7670_DVP_GEN_CHKSUM_EN
    logic [15:0] acc_q, sum_q;

    // Accumulate once per pixel, on the step that leaves its second byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (pclk_q) begin
            if (load_n) acc_q <= '0;
            else if (state_q == ST_ACTIVE && byte_q) acc_q <= acc_q + {4'b0000, pixel};
            if (done_n) sum_q <= acc_q;
        end
    end

    assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_ov7670_dvp_gen.sv
// Self-checking bench for ov7670_dvp_gen with a reduced frame geometry.
// Frame checksum checks are compiled in when OV7670_DVP_GEN_CHKSUM_EN is defined.
module tb_ov7670_dvp_gen;
    import ov7670_dvp_gen_pkg::*;

    localparam int c_cols  = 24;
    localparam int c_rows  = 10;
    localparam int c_vs    = 3;
    localparam int c_vb    = 2;
    localparam int c_vf    = 2;
    localparam int c_hb    = 8;
    localparam int c_line  = 2*c_cols + c_hb;
    localparam int c_frame = (c_vs + c_vb + c_rows + c_vf) * c_line;
    localparam int c_budget = 2*c_frame + 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_rgb;
    logic        pclk, vsync, href, frame_done;
    logic [7:0]  d;
    state_e      dbg_state;
`ifdef OV7670_DVP_GEN_CHKSUM_EN
    logic [15:0] frame_sum;
`endif

    ov7670_dvp_gen #(
        .c_img_cols(c_cols), .c_img_rows(c_rows), .c_vsync_lines(c_vs),
        .c_vback_lines(c_vb), .c_vfront_lines(c_vf), .c_hblank_pclk(c_hb)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .pclk(pclk), .vsync(vsync), .href(href), .d(d),
        .frame_done(frame_done),
`ifdef OV7670_DVP_GEN_CHKSUM_EN
        .frame_sum(frame_sum),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] exp_sum;

    int vs_cnt, h_pulses, h_min, h_max, frame_pclk, done_cnt, blank_bad, edge_bad;
    bit timed_out;

    function automatic logic [11:0] model_pix(input int pat, input int col, input int row,
                                              input logic [11:0] solid);
        int bar;
        case (pat)
            0: return solid;
            1: return {4'(col), 4'(row), 4'h0};
            2: begin
                bar = (col * 8) / c_cols;
                return {bar[2] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[0] ? 4'hF : 4'h0};
            end
            default: return 12'(row * c_cols + col);
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [11:0] solid);
        logic [11:0] p;
        exp_sum = '0;
        for (int r = 0; r < c_rows; r++)
            for (int c = 0; c < c_cols; c++) begin
                p = model_pix(pat, c, r, solid);
                exp_q.push_back({4'h0, p[11:8]});
                exp_q.push_back(p[7:0]);
                exp_sum = exp_sum + 16'(p);
            end
    endtask

    // Monitors one frame until frame_done; optionally disturbs inputs after a given href line.
    task automatic watch_frame(input int disturb_row, input bit drop_en);
        int hcur = 0;
        logic href_prev = 1'b0;
        logic [7:0] d_prev;
        bit started = 1'b0;
        vs_cnt = 0; h_pulses = 0; h_min = 1 << 30; h_max = 0; frame_pclk = 0;
        done_cnt = 0; blank_bad = 0; edge_bad = 0; timed_out = 1'b0;
        got_q.delete();
        d_prev = d;
        for (int i = 0; i < c_budget; i++) begin
            @(negedge clk);
            if (d !== d_prev && pclk === 1'b1) edge_bad++;
            d_prev = d;
            if (frame_done === 1'b1) begin
                done_cnt++;
                break;
            end
            if (pclk === 1'b1) begin
                if (vsync === 1'b1) begin
                    vs_cnt++;
                    started = 1'b1;
                end
                if (started) frame_pclk++;
                if (href === 1'b1) begin
                    got_q.push_back(d);
                    hcur++;
                end else begin
                    if (d !== 8'h00) blank_bad++;
                    if (href_prev === 1'b1) begin
                        h_pulses++;
                        if (hcur < h_min) h_min = hcur;
                        if (hcur > h_max) h_max = hcur;
                        hcur = 0;
                        if (h_pulses == disturb_row) begin
                            pattern_sel = pattern_sel + 2'd1;
                            solid_rgb   = ~solid_rgb;
                            if (drop_en) enable = 1'b0;
                        end
                    end
                end
                href_prev = href;
            end
        end
        if (done_cnt == 0) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 12'h000;
        repeat (5) @(negedge clk);
        n_cmp++; if (pclk !== 1'b0) begin n_err++; $display("FAIL reset_pclk: got %b want 0", pclk); end
        n_cmp++; if (vsync !== 1'b0) begin n_err++; $display("FAIL reset_vsync: got %b want 0", vsync); end
        n_cmp++; if (href !== 1'b0) begin n_err++; $display("FAIL reset_href: got %b want 0", href); end
        n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_d: got %h want 00", d); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL idle_hold: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_solid_timing;
        int bad = 0, idx = 0, fb_idx = 0;
        logic [7:0] g, e, fb_g = 0, fb_e = 0, b0, b1;
        pattern_sel = 2'd0; solid_rgb = 12'hA5C;
        push_frame(0, 12'hA5C);
        enable = 1'b1;
        watch_frame(4, 1'b0);
        enable = 1'b0;
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL solid_timeout: no frame_done within %0d clk", c_budget); end
        b0 = (got_q.size() > 1) ? got_q[0] : 8'hxx;
        b1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
        n_cmp++; if (b0 !== 8'h0A) begin n_err++; $display("FAIL solid_byte0: got %h want 0a", b0); end
        n_cmp++; if (b1 !== 8'h5C) begin n_err++; $display("FAIL solid_byte1: got %h want 5c", b1); end
        n_cmp++; if (vs_cnt !== c_vs*c_line) begin n_err++; $display("FAIL vsync_len: got %0d want %0d", vs_cnt, c_vs*c_line); end
        n_cmp++; if (h_pulses !== c_rows) begin n_err++; $display("FAIL href_count: got %0d want %0d", h_pulses, c_rows); end
        n_cmp++; if (h_min !== 2*c_cols || h_max !== 2*c_cols) begin n_err++; $display("FAIL href_width: got %0d..%0d want %0d", h_min, h_max, 2*c_cols); end
        n_cmp++; if (frame_pclk !== c_frame) begin n_err++; $display("FAIL frame_len: got %0d want %0d", frame_pclk, c_frame); end
        n_cmp++; if (blank_bad !== 0) begin n_err++; $display("FAIL blank_data: got %0d nonzero want 0", blank_bad); end
        n_cmp++; if (edge_bad !== 0) begin n_err++; $display("FAIL data_edge: got %0d changes on pclk rise want 0", edge_bad); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin if (bad == 0) begin fb_idx = idx; fb_g = g; fb_e = e; end bad++; end
            idx++;
        end
        bad += got_q.size() + exp_q.size();
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL solid_bytes: %0d bad, first at %0d got %h want %h", bad, fb_idx, fb_g, fb_e); end
`ifdef OV7670_DVP_GEN_CHKSUM_EN
        n_cmp++; if (frame_sum !== exp_sum) begin n_err++; $display("FAIL solid_sum: got %h want %h", frame_sum, exp_sum); end
`endif
        got_q.delete(); exp_q.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_patterns;
        int bad, idx, fb_idx;
        logic [7:0] g, e, fb_g, fb_e, l0, l1;
        logic [11:0] s, lp;
        for (int pat = 1; pat <= 3; pat++) begin
            bad = 0; idx = 0; fb_idx = 0; fb_g = 0; fb_e = 0;
            s = 12'($urandom_range(0, 4095));
            solid_rgb = s; pattern_sel = 2'(pat);
            push_frame(pat, s);
            enable = 1'b1;
            watch_frame(-1, 1'b0);
            enable = 1'b0;
            n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL pat%0d_done: got %0d want 1", pat, done_cnt); end
            lp = model_pix(pat, c_cols-1, c_rows-1, s);
            l0 = (got_q.size() > 1) ? got_q[got_q.size()-2] : 8'hxx;
            l1 = (got_q.size() > 1) ? got_q[got_q.size()-1] : 8'hxx;
            n_cmp++; if (l0 !== {4'h0, lp[11:8]} || l1 !== lp[7:0]) begin
                n_err++; $display("FAIL pat%0d_last_pixel: got %h %h want %h %h", pat, l0, l1, {4'h0, lp[11:8]}, lp[7:0]);
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin if (bad == 0) begin fb_idx = idx; fb_g = g; fb_e = e; end bad++; end
                idx++;
            end
            bad += got_q.size() + exp_q.size();
            n_cmp++; if (bad != 0) begin n_err++; $display("FAIL pat%0d_bytes: %0d bad, first at %0d got %h want %h", pat, bad, fb_idx, fb_g, fb_e); end
`ifdef OV7670_DVP_GEN_CHKSUM_EN
            n_cmp++; if (frame_sum !== exp_sum) begin n_err++; $display("FAIL pat%0d_sum: got %h want %h", pat, frame_sum, exp_sum); end
`endif
            got_q.delete(); exp_q.delete();
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int bad, idx, fb_idx;
        logic [7:0] g, e, fb_g, fb_e;
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            bad = 0; idx = 0; fb_idx = 0; fb_g = 0; fb_e = 0;
            pattern_sel = (f == 0) ? 2'd1 : 2'd2;
            push_frame(f == 0 ? 1 : 2, solid_rgb);
            watch_frame(-1, 1'b0);
            n_cmp++; if (timed_out) begin n_err++; $display("FAIL b2b%0d_timeout: no frame_done within %0d clk", f, c_budget); end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin if (bad == 0) begin fb_idx = idx; fb_g = g; fb_e = e; end bad++; end
                idx++;
            end
            bad += got_q.size() + exp_q.size();
            n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b%0d_bytes: %0d bad, first at %0d got %h want %h", f, bad, fb_idx, fb_g, fb_e); end
            got_q.delete(); exp_q.delete();
        end
        enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_enable_drop;
        int bad = 0, idx = 0, fb_idx = 0, extra_done = 0, extra_vs = 0;
        logic [7:0] g, e, fb_g = 0, fb_e = 0;
        pattern_sel = 2'd3;
        push_frame(3, solid_rgb);
        enable = 1'b1;
        watch_frame(c_rows/2, 1'b1);
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL drop_done: got %0d want 1", done_cnt); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin if (bad == 0) begin fb_idx = idx; fb_g = g; fb_e = e; end bad++; end
            idx++;
        end
        bad += got_q.size() + exp_q.size();
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL drop_bytes: %0d bad, first at %0d got %h want %h", bad, fb_idx, fb_g, fb_e); end
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 4*c_line; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) extra_done++;
            if (vsync === 1'b1) extra_vs++;
        end
        n_cmp++; if (extra_done !== 0 || extra_vs !== 0) begin n_err++; $display("FAIL drop_restart: got %0d done %0d vsync want 0 0", extra_done, extra_vs); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL drop_idle: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_reset_mid;
        int bad = 0, idx = 0, fb_idx = 0, rises = 0;
        logic [7:0] g, e, fb_g = 0, fb_e = 0;
        logic href_prev = 1'b0;
        bit hit = 1'b0;
        pattern_sel = 2'd1; solid_rgb = 12'h3C7;
        enable = 1'b1;
        for (int i = 0; i < c_budget && !hit; i++) begin
            @(negedge clk);
            if (href === 1'b1 && href_prev !== 1'b1) rises++;
            href_prev = href;
            if (rises == 4 && href === 1'b1) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL rstmid_reach: got %0d href lines want 4", rises); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({pclk, vsync, href, frame_done} !== 4'b0000 || d !== 8'h00) begin
            n_err++; $display("FAIL rstmid_outputs: got pclk%b vs%b href%b done%b d%h want all 0", pclk, vsync, href, frame_done, d);
        end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        rst = 1'b0;
        push_frame(1, 12'h3C7);
        watch_frame(-1, 1'b0);
        enable = 1'b0;
        n_cmp++; if (vs_cnt !== c_vs*c_line) begin n_err++; $display("FAIL rstmid_vsync: got %0d want %0d", vs_cnt, c_vs*c_line); end
        n_cmp++; if (h_pulses !== c_rows) begin n_err++; $display("FAIL rstmid_lines: got %0d want %0d", h_pulses, c_rows); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin if (bad == 0) begin fb_idx = idx; fb_g = g; fb_e = e; end bad++; end
            idx++;
        end
        bad += got_q.size() + exp_q.size();
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rstmid_bytes: %0d bad, first at %0d got %h want %h", bad, fb_idx, fb_g, fb_e); end
        got_q.delete(); exp_q.delete();
        repeat (6) @(negedge clk);
    endtask

`ifdef OV7670_DVP_GEN_CHKSUM_EN
    task automatic test_chksum;
        pattern_sel = 2'd0; solid_rgb = 12'h001;
        enable = 1'b1;
        watch_frame(-1, 1'b0);
        enable = 1'b0;
        n_cmp++; if (frame_sum !== 16'(c_rows*c_cols)) begin n_err++; $display("FAIL chksum_unit: got %h want %h", frame_sum, 16'(c_rows*c_cols)); end
        got_q.delete();
        repeat (6) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_solid_timing();
        test_patterns();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
`ifdef OV7670_DVP_GEN_CHKSUM_EN
        test_chksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
